// File: rtl/periph_bus_bridge_if.sv
// Peripheral-side bus of periph_bus_bridge: one-hot select, shared
// local address / write data, strobes, per-channel read data, bus error.
interface periph_bus_bridge_if #(
   parameter int NUM_PERIP = 8,
   parameter int DATA_W    = 8,
   parameter int PSEL_LSB  = 11
);
   logic [NUM_PERIP-1:0]        p_cs;
   logic [PSEL_LSB-1:0]         p_addr;
   logic [DATA_W-1:0]           p_wdata;
   logic                        p_we;
   logic                        p_re;
   logic [NUM_PERIP*DATA_W-1:0] p_rdata;
   logic                        bus_err;

   modport master (
      output p_cs, p_addr, p_wdata, p_we, p_re, bus_err,
      input  p_rdata
   );

   modport slave (
      input  p_cs, p_addr, p_wdata, p_we, p_re, bus_err,
      output p_rdata
   );
endinterface

// File: rtl/periph_bus_bridge.sv
// Async CPU bus (ncs/nwe/nrd/address/data_bus) to NUM_PERIP peripherals.
// Ports: clk, reset (async, active-high), CPU bus pins, pb (master side
// of periph_bus_bridge_if). Macro BRIDGE_STATS_EN adds wr_count/rd_count.
module periph_bus_bridge #(
   parameter int CLK_FREQ    = 96000000,
   parameter int NUM_PERIP   = 8,
   parameter int ADDR_W      = 14,
   parameter int DATA_W      = 8,
   parameter int PSEL_LSB    = 11,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                ncs,
   input  logic                nwe,
   input  logic                nrd,
   input  logic [ADDR_W-1:0]   address,
   inout  wire  [DATA_W-1:0]   data_bus,
   periph_bus_bridge_if.master pb
`ifdef BRIDGE_STATS_EN
   ,
   output logic [15:0]         wr_count,
   output logic [15:0]         rd_count
`endif
);

   localparam int IDX_W = ADDR_W - PSEL_LSB;
   localparam int PW    = $clog2(SYNC_STAGES + 1);

   // CLK_FREQ is informational only.
   if (CLK_FREQ <= 0) begin : g_clk_unset
   end

   typedef enum logic [1:0] {WAIT_IDLE, IDLE, WRITE, READ} state_t;

   state_t                 st;
   logic [SYNC_STAGES-1:0] ncs_sr, nwe_sr, nrd_sr;
   logic [PW-1:0]          prime;
   logic [ADDR_W-1:0]      addr_q;
   logic [DATA_W-1:0]      data_q;
   logic [DATA_W-1:0]      rd_bus;
   logic [DATA_W-1:0]      rsel;
   logic [IDX_W-1:0]       idx, w_idx;
   logic [PSEL_LSB-1:0]    loc;
   logic [NUM_PERIP-1:0]   rd_cs, wr_cs;
   logic                   s_ncs, s_nwe, s_nrd;
   logic                   wr_act, rd_act, primed;

   function automatic logic [NUM_PERIP-1:0] dec(input logic [IDX_W-1:0] ix);
      dec = '0;
      for (int i = 0; i < NUM_PERIP; i++)
         if ({1'b0, ix} == (IDX_W+1)'(i)) dec[i] = 1'b1;
   endfunction

   assign s_ncs  = ncs_sr[SYNC_STAGES-1];
   assign s_nwe  = nwe_sr[SYNC_STAGES-1];
   assign s_nrd  = nrd_sr[SYNC_STAGES-1];
   assign wr_act = ~s_ncs & ~s_nwe;
   assign rd_act = ~s_ncs & ~s_nrd & s_nwe;
   assign primed = (prime == PW'(SYNC_STAGES));

   assign idx   = addr_q[ADDR_W-1:PSEL_LSB];
   assign loc   = addr_q[PSEL_LSB-1:0];
   assign rd_cs = dec(idx);
   assign wr_cs = dec(w_idx);

   always_comb begin
      rsel = '0;
      for (int i = 0; i < NUM_PERIP; i++)
         if (rd_cs[i]) rsel = pb.p_rdata[i*DATA_W +: DATA_W];
   end

   assign data_bus = (ncs | nrd) ? 'z : rd_bus;

   // The synchroniser resets to idle, so its output only reflects the real
   // pins after SYNC_STAGES clocks; prime holds WAIT_IDLE until then so an
   // access in flight at reset release is never mistaken for a new one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ncs_sr <= '1;
         nwe_sr <= '1;
         nrd_sr <= '1;
         prime  <= '0;
         addr_q <= '0;
         data_q <= '0;
         rd_bus <= '0;
      end else begin
         ncs_sr <= {ncs_sr[SYNC_STAGES-2:0], ncs};
         nwe_sr <= {nwe_sr[SYNC_STAGES-2:0], nwe};
         nrd_sr <= {nrd_sr[SYNC_STAGES-2:0], nrd};
         if (!primed) prime <= prime + PW'(1);
         addr_q <= address;
         data_q <= data_bus;
         rd_bus <= rsel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= WAIT_IDLE;
         w_idx      <= '0;
         pb.p_cs    <= '0;
         pb.p_addr  <= '0;
         pb.p_wdata <= '0;
         pb.p_we    <= 1'b0;
         pb.p_re    <= 1'b0;
         pb.bus_err <= 1'b0;
      end else begin
         pb.p_cs    <= '0;
         pb.p_we    <= 1'b0;
         pb.p_re    <= 1'b0;
         pb.bus_err <= 1'b0;
         unique case (st)
            WAIT_IDLE: begin
               if (primed && s_ncs) st <= IDLE;
            end
            IDLE: begin
               if (wr_act) begin
                  st         <= WRITE;
                  w_idx      <= idx;
                  pb.p_addr  <= loc;
                  pb.p_wdata <= data_q;
               end else if (rd_act) begin
                  st         <= READ;
                  pb.p_addr  <= loc;
                  pb.p_cs    <= rd_cs;
                  pb.p_re    <= |rd_cs;
                  pb.bus_err <= ~|rd_cs;
               end
            end
            WRITE: begin
               // Commit on the trailing edge with the last stable values.
               if (wr_act) begin
                  w_idx      <= idx;
                  pb.p_addr  <= loc;
                  pb.p_wdata <= data_q;
               end else begin
                  st         <= IDLE;
                  pb.p_cs    <= wr_cs;
                  pb.p_we    <= |wr_cs;
                  pb.bus_err <= ~|wr_cs;
               end
            end
            READ: begin
               if (s_ncs | s_nrd) st <= IDLE;
            end
            default: st <= WAIT_IDLE;
         endcase
      end
   end

`ifdef BRIDGE_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_count <= '0;
         rd_count <= '0;
      end else begin
         if (pb.p_we && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
         if (pb.p_re && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Randomised bench for periph_bus_bridge against a transaction-level
// model of peripheral strobes, decode and read-back data.
module tb_periph_bus_bridge;
   localparam int NP = 6;
   localparam int AW = 14;
   localparam int DW = 8;
   localparam int PL = 11;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ncs = 1'b1;
   logic          nwe = 1'b1;
   logic          nrd = 1'b1;
   logic [AW-1:0] address = '0;
   logic          drv_en = 1'b0;
   logic [DW-1:0] drv_val = '0;
   wire  [DW-1:0] data_bus;
   logic [DW-1:0] mem [NP];

   int checks = 0;
   int errors = 0;
   int we_n, re_n, err_n;
   int viol_n = 0;
   int exp_wr = 0;
   int exp_rd = 0;
   logic [NP-1:0] we_cs, re_cs;
   logic [PL-1:0] we_addr, re_addr;
   logic [DW-1:0] we_data;

   assign data_bus = drv_en ? drv_val : 'z;

   periph_bus_bridge_if #(.NUM_PERIP(NP), .DATA_W(DW), .PSEL_LSB(PL)) pb ();

   for (genvar g = 0; g < NP; g++) begin : g_rd
      assign pb.p_rdata[g*DW +: DW] = mem[g];
   end

`ifdef BRIDGE_STATS_EN
   wire [15:0] wr_count, rd_count;
`endif

   periph_bus_bridge #(
      .CLK_FREQ(96000000), .NUM_PERIP(NP), .ADDR_W(AW),
      .DATA_W(DW), .PSEL_LSB(PL), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .reset(reset), .ncs(ncs), .nwe(nwe), .nrd(nrd),
      .address(address), .data_bus(data_bus), .pb(pb)
`ifdef BRIDGE_STATS_EN
      , .wr_count(wr_count), .rd_count(rd_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pb.p_we) begin
         we_n++;
         we_cs   = pb.p_cs;
         we_addr = pb.p_addr;
         we_data = pb.p_wdata;
      end
      if (pb.p_re) begin
         re_n++;
         re_cs   = pb.p_cs;
         re_addr = pb.p_addr;
      end
      if (pb.bus_err) err_n++;
      if (pb.p_we && pb.p_re) viol_n++;
      if (!pb.p_we && !pb.p_re && pb.p_cs != '0) viol_n++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clr();
      we_n  = 0;
      re_n  = 0;
      err_n = 0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int hold, input bit rd_too);
      int  idx;
      bit  hit;
      idx = int'(a >> PL);
      hit = idx < NP;
      clr();
      address = a;
      drv_val = d;
      drv_en  = !rd_too;
      ncs = 1'b0;
      nwe = 1'b0;
      nrd = !rd_too;
      cyc(hold);
      ncs = 1'b1;
      nwe = 1'b1;
      nrd = 1'b1;
      cyc(SS + 2);
      drv_en = 1'b0;
      cyc(4);
      if (hit) exp_wr++;
      chk("wr_we", 32'(we_n), 32'(hit));
      chk("wr_re", 32'(re_n), 32'd0);
      chk("wr_err", 32'(err_n), 32'(!hit));
      if (hit) begin
         chk("wr_cs", 32'(we_cs), 32'(1) << idx);
         chk("wr_addr", 32'(we_addr), 32'(a) % 32'd2048);
         if (!rd_too) chk("wr_data", 32'(we_data), 32'(d));
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a, input int hold);
      int            idx;
      bit            hit;
      logic [DW-1:0] seen;
      idx = int'(a >> PL);
      hit = idx < NP;
      clr();
      address = a;
      ncs = 1'b0;
      nrd = 1'b0;
      cyc(4);
      seen = data_bus;
      cyc(hold - 4);
      ncs = 1'b1;
      nrd = 1'b1;
      cyc(6);
      if (hit) exp_rd++;
      chk("rd_data", 32'(seen), hit ? 32'(mem[idx]) : 32'd0);
      chk("rd_re", 32'(re_n), 32'(hit));
      chk("rd_we", 32'(we_n), 32'd0);
      chk("rd_err", 32'(err_n), 32'(!hit));
      if (hit) begin
         chk("rd_cs", 32'(re_cs), 32'(1) << idx);
         chk("rd_addr", 32'(re_addr), 32'(a) % 32'd2048);
      end
   endtask

   initial begin
      for (int i = 0; i < NP; i++) mem[i] = DW'($urandom);
      cyc(3);
      chk("rst_cs", 32'(pb.p_cs), 32'd0);
      chk("rst_we", 32'(pb.p_we), 32'd0);
      chk("rst_re", 32'(pb.p_re), 32'd0);
      chk("rst_err", 32'(pb.bus_err), 32'd0);
      chk("rst_addr", 32'(pb.p_addr), 32'd0);
      chk("rst_wdata", 32'(pb.p_wdata), 32'd0);
      reset = 1'b0;
      cyc(5);

      do_write({3'd2, 11'h005}, 8'hA5, 6, 1'b0);
      mem[5] = 8'h3C;
      do_read({3'd5, 11'h1F0}, 8);
      do_write({3'd7, 11'h010}, 8'h11, 5, 1'b0);
      do_read({3'd7, 11'h010}, 8);
      do_write({3'd1, 11'h2AB}, 8'h00, 5, 1'b1);

      // Reset asserted mid-write, released with the strobes still low.
      clr();
      address = {3'd1, 11'h123};
      drv_val = 8'h5A;
      drv_en  = 1'b1;
      ncs = 1'b0;
      nwe = 1'b0;
      cyc(4);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      exp_wr = 0;
      exp_rd = 0;
      cyc(5);
      ncs = 1'b1;
      nwe = 1'b1;
      cyc(4);
      drv_en = 1'b0;
      cyc(4);
      chk("rst_drop_we", 32'(we_n), 32'd0);
      chk("rst_drop_err", 32'(err_n), 32'd0);
      do_write({3'd1, 11'h123}, 8'h5A, 4, 1'b0);

      for (int n = 0; n < 40; n++) begin
         logic [AW-1:0] a;
         a = AW'($urandom_range(0, (1 << AW) - 1));
         if ($urandom_range(0, 1) == 0) begin
            do_write(a, DW'($urandom), int'($urandom_range(2, 8)),
                     $urandom_range(0, 5) == 0);
         end else begin
            mem[$urandom_range(0, NP - 1)] = DW'($urandom);
            do_read(a, int'($urandom_range(5, 9)));
         end
      end

`ifdef BRIDGE_STATS_EN
      chk("wr_count", 32'(wr_count), 32'(exp_wr));
      chk("rd_count", 32'(rd_count), 32'(exp_rd));
`endif
      chk("invariants", 32'(viol_n), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
